cpu_trace_buffer: RTL and testbench

Parametrised hardware execution tracer for the single-cycle CPU. It gates the CPU clock-enable, captures one record per executed instruction (cycle, PC, instruction, ALU result) into an on-chip buffer, and stops on syscall or a cycle-limit watchdog. It then drains the captured records through a valid/ready port. It sits beside the CPU top level and replaces the per-cycle printing and cycle cap in the CPU bench with a synthesizable equivalent.

---
 rtl/cpu_trace_pkg.sv | 26 ++
 rtl/cpu_trace_buffer_if.sv | 14 +
 rtl/trace_ram.sv | 28 ++
 rtl/cpu_trace_buffer.sv | 152 +++++++++++++++
 tb/tb_cpu_trace_buffer.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_trace_pkg.sv
// Shared types for the CPU execution tracer: FSM states, halt causes and the
// per-instruction payload captured alongside the cycle index.
package cpu_trace_pkg;

  localparam int unsigned WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_e;

  typedef enum logic [1:0] {
    HALT_NONE    = 2'b00,
    HALT_SYSCALL = 2'b01,
    HALT_WDOG    = 2'b10
  } halt_cause_e;

  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] instr;
    logic [WORD_W-1:0] alu;
  } trace_fields_t;

endpackage

// File: rtl/cpu_trace_buffer_if.sv
// Record drain port: the tracer is the master (source), the consumer the slave.
interface cpu_trace_buffer_if #(
  parameter int unsigned CYC_W = 32
);
  logic             rd_valid;
  logic             rd_ready;
  logic [CYC_W-1:0] rd_cycle;
  logic [31:0]      rd_pc;
  logic [31:0]      rd_instr;
  logic [31:0]      rd_alu;

  modport master (output rd_valid, rd_cycle, rd_pc, rd_instr, rd_alu, input rd_ready);
  modport slave  (input rd_valid, rd_cycle, rd_pc, rd_instr, rd_alu, output rd_ready);
endinterface

// File: rtl/trace_ram.sv
// Simple dual-port record store: one write port, one registered read port.
// A read of the address being written in the same cycle returns the new data.
module trace_ram #(
  parameter int unsigned DEPTH = 128,
  parameter int unsigned WIDTH = 128
) (
  input  logic                     clock,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     re_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // NOTE: the array and its read register carry no reset so they map onto block
  // RAM; every consumer qualifies the read data with its own reset valid flag.
  always_ff @(posedge clock) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= (we_i && (waddr_i == raddr_i)) ? wdata_i : mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/cpu_trace_buffer.sv
// Execution tracer: gates the CPU, records one entry per executed instruction,
// halts on syscall or watchdog, then drains the records oldest-first.
module cpu_trace_buffer
  import cpu_trace_pkg::*;
#(
  parameter int unsigned DEPTH      = 128,
  parameter int unsigned CYC_W      = 32,
  parameter int unsigned MAX_CYCLES = 50000,
  parameter int unsigned MODE       = 0
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic [31:0]              pc,
  input  logic [31:0]              instruction,
  input  logic [31:0]              alu_result,
  input  logic                     syscall,
  output logic                     cpu_enable,
  cpu_trace_buffer_if.master       rd,
  output logic                     halted,
  output logic [1:0]               halt_cause,
  output logic [CYC_W-1:0]         cycle_count,
  output logic [$clog2(DEPTH):0]   entries,
  output logic                     overflow
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned REC_W = CYC_W + $bits(trace_fields_t);
  localparam logic [CNT_W-1:0] FULL      = CNT_W'(DEPTH);
  localparam logic [CYC_W-1:0] WDOG_LAST = CYC_W'(MAX_CYCLES - 1);

  typedef struct packed {
    logic [CYC_W-1:0] cycle;
    trace_fields_t    data;
  } rec_t;

  state_e            state_q;
  halt_cause_e       cause_q;
  logic [CYC_W-1:0]  cycle_q;
  logic [CNT_W-1:0]  entries_q;
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q, rd_ptr_d;
  logic              overflow_q;
  rec_t              pf_q;
  logic              pf_valid_q;

  logic              running, full, halt_now, ram_we, advance;
  rec_t              wr_rec;
  logic [REC_W-1:0]  ram_rdata;

  assign running  = (state_q == RUN);
  assign full     = (entries_q == FULL);
  assign halt_now = running && (syscall || (cycle_q == WDOG_LAST));
  assign ram_we   = running && (!full || (MODE != 0));
  assign wr_rec   = {cycle_q, pc, instruction, alu_result};

  // The RAM read runs one record ahead of the prefetch register: the halting
  // capture issues the first read, and every prefetch load issues the next.
  assign advance = (state_q == DRAIN) && (entries_q != '0) &&
                   (!pf_valid_q || (rd.rd_ready && (entries_q != CNT_W'(1))));

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    if ((running && full && (MODE != 0)) || advance) rd_ptr_d = rd_ptr_q + PTR_W'(1);
  end

  trace_ram #(.DEPTH(DEPTH), .WIDTH(REC_W)) u_ram (
    .clock   (clock),
    .we_i    (ram_we),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_rec),
    .re_i    (halt_now || advance),
    .raddr_i (rd_ptr_d),
    .rdata_o (ram_rdata)
  );

  // NOTE: state registers use non-blocking assignments so every update in this
  // block sees the pre-edge values; later assignments override earlier ones.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cause_q    <= HALT_NONE;
      cycle_q    <= '0;
      entries_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
      pf_q       <= '0;
      pf_valid_q <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      if (advance) pf_q <= rec_t'(ram_rdata);
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q    <= RUN;
            cause_q    <= HALT_NONE;
            cycle_q    <= '0;
            entries_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
          end
        end
        RUN: begin
          if (cycle_q != '1) cycle_q <= cycle_q + CYC_W'(1);
          if (ram_we) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
          if (!full) entries_q <= entries_q + CNT_W'(1);
          else       overflow_q <= 1'b1;
          if (syscall) begin
            cause_q <= HALT_SYSCALL;
            state_q <= DRAIN;
          end else if (cycle_q == WDOG_LAST) begin
            cause_q <= HALT_WDOG;
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (pf_valid_q) begin
            if (rd.rd_ready) begin
              entries_q <= entries_q - CNT_W'(1);
              if (entries_q == CNT_W'(1)) begin
                pf_valid_q <= 1'b0;
                state_q    <= DONE;
              end
            end
          end else if (entries_q == '0) begin
            state_q <= DONE;
          end else begin
            pf_valid_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cpu_enable  = running;
  assign halted      = (state_q == DONE);
  assign halt_cause  = cause_q;
  assign cycle_count = cycle_q;
  assign entries     = entries_q;
  assign overflow    = overflow_q;

  assign rd.rd_valid = pf_valid_q;
  assign rd.rd_cycle = pf_q.cycle;
  assign rd.rd_pc    = pf_q.data.pc;
  assign rd.rd_instr = pf_q.data.instr;
  assign rd.rd_alu   = pf_q.data.alu;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Directed bench for cpu_trace_buffer: three instances (MODE 0 / MODE 1 at depth 8,
// depth 32 with a 20-cycle watchdog) driven one at a time through a selector.
module tb_cpu_trace_buffer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        start_drv = 1'b0, sys_drv = 1'b0, ready_drv = 1'b0;
  logic [31:0] pc_drv = '0, instr_drv = '0, alu_drv = '0;
  int          sel = 0;
  int          n_checks = 0, n_errors = 0;

  logic        en [3];
  logic        hlt [3];
  logic        ovf [3];
  logic [1:0]  cause [3];
  logic [31:0] ccount [3];
  logic [3:0]  ent0, ent1;
  logic [5:0]  ent2;

  cpu_trace_buffer_if rif0 ();
  cpu_trace_buffer_if rif1 ();
  cpu_trace_buffer_if rif2 ();
  assign rif0.rd_ready = ready_drv && (sel == 0);
  assign rif1.rd_ready = ready_drv && (sel == 1);
  assign rif2.rd_ready = ready_drv && (sel == 2);

  cpu_trace_buffer #(.DEPTH(8), .CYC_W(32), .MAX_CYCLES(20), .MODE(0)) u_dut0 (
    .clock(clk), .reset(rst), .start(start_drv && (sel == 0)), .pc(pc_drv),
    .instruction(instr_drv), .alu_result(alu_drv), .syscall(sys_drv && (sel == 0)),
    .cpu_enable(en[0]), .rd(rif0), .halted(hlt[0]), .halt_cause(cause[0]),
    .cycle_count(ccount[0]), .entries(ent0), .overflow(ovf[0]));

  cpu_trace_buffer #(.DEPTH(8), .CYC_W(32), .MAX_CYCLES(20), .MODE(1)) u_dut1 (
    .clock(clk), .reset(rst), .start(start_drv && (sel == 1)), .pc(pc_drv),
    .instruction(instr_drv), .alu_result(alu_drv), .syscall(sys_drv && (sel == 1)),
    .cpu_enable(en[1]), .rd(rif1), .halted(hlt[1]), .halt_cause(cause[1]),
    .cycle_count(ccount[1]), .entries(ent1), .overflow(ovf[1]));

  cpu_trace_buffer #(.DEPTH(32), .CYC_W(32), .MAX_CYCLES(20), .MODE(0)) u_dut2 (
    .clock(clk), .reset(rst), .start(start_drv && (sel == 2)), .pc(pc_drv),
    .instruction(instr_drv), .alu_result(alu_drv), .syscall(sys_drv && (sel == 2)),
    .cpu_enable(en[2]), .rd(rif2), .halted(hlt[2]), .halt_cause(cause[2]),
    .cycle_count(ccount[2]), .entries(ent2), .overflow(ovf[2]));

  logic         m_valid, m_en, m_halted, m_ovf;
  logic [1:0]   m_cause;
  logic [31:0]  m_ccount, m_entries;
  logic [127:0] m_rec;

  always_comb begin
    m_valid   = 1'b0;
    m_rec     = '0;
    m_entries = '0;
    case (sel)
      0: begin
        m_valid   = rif0.rd_valid;
        m_rec     = {rif0.rd_cycle, rif0.rd_pc, rif0.rd_instr, rif0.rd_alu};
        m_entries = 32'(ent0);
      end
      1: begin
        m_valid   = rif1.rd_valid;
        m_rec     = {rif1.rd_cycle, rif1.rd_pc, rif1.rd_instr, rif1.rd_alu};
        m_entries = 32'(ent1);
      end
      default: begin
        m_valid   = rif2.rd_valid;
        m_rec     = {rif2.rd_cycle, rif2.rd_pc, rif2.rd_instr, rif2.rd_alu};
        m_entries = 32'(ent2);
      end
    endcase
    m_en     = en[sel];
    m_halted = hlt[sel];
    m_ovf    = ovf[sel];
    m_cause  = cause[sel];
    m_ccount = ccount[sel];
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Record the CPU stimulus produces at cycle c.
  function automatic logic [127:0] exp_rec(input int c);
    return {32'(c), 32'h3000 + 32'(4 * c), 32'h1000_0000 + 32'(c), 32'hA5A5_0000 ^ 32'(c)};
  endfunction

  task automatic check_reset(input string tag);
    check({tag, "_en"}, 128'(m_en), 128'(0));
    check({tag, "_valid"}, 128'(m_valid), 128'(0));
    check({tag, "_halted"}, 128'(m_halted), 128'(0));
    check({tag, "_ovf"}, 128'(m_ovf), 128'(0));
    check({tag, "_cause"}, 128'(m_cause), 128'(0));
    check({tag, "_ccount"}, 128'(m_ccount), 128'(0));
    check({tag, "_entries"}, 128'(m_entries), 128'(0));
    check({tag, "_rec"}, m_rec, 128'(0));
  endtask

  // Pulse start, then feed one instruction per cycle while cpu_enable is high.
  task automatic run(input int sys_at, output int n);
    start_drv = 1'b1;
    @(posedge clk); #1;
    start_drv = 1'b0;
    n = 0;
    while (m_en && n < 100) begin
      pc_drv    = 32'h3000 + 32'(4 * n);
      instr_drv = 32'h1000_0000 + 32'(n);
      alu_drv   = 32'hA5A5_0000 ^ 32'(n);
      sys_drv   = (n == sys_at);
      @(posedge clk); #1;
      n++;
    end
    sys_drv = 1'b0;
  endtask

  // Whenever rd_valid is high the record must be the next expected one,
  // which covers both in-order delivery and stability while stalled.
  task automatic drain(input int n_exp, input int first, input bit toggle);
    int got = 0;
    for (int cyc = 0; cyc < 200 && got < n_exp; cyc++) begin
      ready_drv = toggle ? (cyc % 2 == 0) : 1'b1;
      if (m_valid) begin
        check("rd_rec", m_rec, exp_rec(first + got));
        if (ready_drv) begin
          got++;
          if (got == n_exp) check("halted_before_last_pop", 128'(m_halted), 128'(0));
        end
      end
      @(posedge clk); #1;
    end
    ready_drv = 1'b0;
    check("drain_count", 128'(got), 128'(n_exp));
    check("halted_after_last_pop", 128'(m_halted), 128'(1));
    check("valid_in_done", 128'(m_valid), 128'(0));
    check("entries_in_done", 128'(m_entries), 128'(0));
  endtask

  initial begin
    int n;
    rst = 1'b1;
    #12;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      check_reset("reset");
    end
    @(posedge clk); #1;
    rst = 1'b0;

    // Syscall halt, MODE 0 depth 8.
    sel = 0; #1;
    run(4, n);
    check("sys_records", 128'(n), 128'(5));
    check("sys_cause", 128'(m_cause), 128'(2'b01));
    check("sys_ccount", 128'(m_ccount), 128'(5));
    check("sys_entries", 128'(m_entries), 128'(5));
    check("sys_ovf", 128'(m_ovf), 128'(0));
    check("sys_en_low", 128'(m_en), 128'(0));
    check("sys_valid_at_entry", 128'(m_valid), 128'(0));
    @(posedge clk); #1;
    check("sys_valid_rise", 128'(m_valid), 128'(1));
    drain(5, 0, 1'b0);
    check("sys_cause_held", 128'(m_cause), 128'(2'b01));

    // MODE 0 overflow: keep the first 8 of 12.
    run(11, n);
    check("ovf0_records", 128'(n), 128'(12));
    check("ovf0_entries", 128'(m_entries), 128'(8));
    check("ovf0_flag", 128'(m_ovf), 128'(1));
    check("ovf0_ccount", 128'(m_ccount), 128'(12));
    drain(8, 0, 1'b0);

    // MODE 1 ring: keep the last 8 of 12, drained with alternating backpressure.
    sel = 1; #1;
    run(11, n);
    check("ring_records", 128'(n), 128'(12));
    check("ring_entries", 128'(m_entries), 128'(8));
    check("ring_flag", 128'(m_ovf), 128'(1));
    drain(8, 4, 1'b1);

    // Syscall on the very first cycle: single record, write and first read collide.
    run(0, n);
    check("one_records", 128'(n), 128'(1));
    check("one_entries", 128'(m_entries), 128'(1));
    check("one_ovf_cleared", 128'(m_ovf), 128'(0));
    drain(1, 0, 1'b0);

    // Watchdog at 20 cycles, depth 32.
    sel = 2; #1;
    run(-1, n);
    check("wdog_records", 128'(n), 128'(20));
    check("wdog_en_low", 128'(m_en), 128'(0));
    check("wdog_cause", 128'(m_cause), 128'(2'b10));
    check("wdog_ccount", 128'(m_ccount), 128'(20));
    check("wdog_entries", 128'(m_entries), 128'(20));
    check("wdog_ovf", 128'(m_ovf), 128'(0));
    drain(20, 0, 1'b0);

    // Syscall on the watchdog cycle, then reset mid-DRAIN.
    sel = 0; #1;
    run(19, n);
    check("coll_records", 128'(n), 128'(20));
    check("coll_cause", 128'(m_cause), 128'(2'b01));
    check("coll_entries", 128'(m_entries), 128'(8));
    ready_drv = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    ready_drv = 1'b0;
    check("coll_entries_after_pop", 128'(m_entries), 128'(7));
    check("coll_second_rec", m_rec, exp_rec(1));
    #1;
    rst = 1'b1;
    #1;
    check_reset("async_reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Fresh capture after reset.
    run(2, n);
    check("fresh_records", 128'(n), 128'(3));
    check("fresh_ccount", 128'(m_ccount), 128'(3));
    check("fresh_ovf", 128'(m_ovf), 128'(0));
    drain(3, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
